apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one APB master port between NUM_REQ requesters, e.g. the AHB-to-APB bridge, a DMA engine and a debug port.
//  - Arbitration: round-robin, non-preemptive.
//  - Runs the APB SETUP/ACCESS sequence and honours PREADY wait states.
//  - Returns read data and error status to the granted requester.
//  - A watchdog terminates transfers whose slave never asserts PREADY.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  ADDR_WIDTH  32  APB address width
//  DATA_WIDTH  32  APB data width
//  TIMEOUT     16  max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables the watchdog
// PORTS
//  HCLK         in   1                     single clock
//  HRESETn      in   1                     asynchronous active-low reset
//  req_valid    in   NUM_REQ               per-requester transfer request, held until req_done
//  req_write    in   NUM_REQ               1=write, 0=read
//  req_addr     in   NUM_REQ*ADDR_WIDTH    packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata    in   NUM_REQ*DATA_WIDTH    packed, same layout as req_addr
//  req_gnt      out  NUM_REQ               one-hot owner of the APB bus, SETUP through ACCESS
//  req_done     out  NUM_REQ               one-hot, one-cycle completion strobe
//  rsp_rdata    out  DATA_WIDTH            read data, valid when any req_done=1
//  rsp_err      out  1                     PSLVERR or timeout, valid when any req_done=1
//  timeout_evt  out  1                     one-cycle pulse on watchdog abort
//  PSEL PENABLE PWRITE  out  1             APB control
//  PADDR        out  ADDR_WIDTH            APB address
//  PWDATA       out  DATA_WIDTH            APB write data
//  PRDATA       in   DATA_WIDTH            APB read data
//  PREADY       in   1                     APB ready
//  PSLVERR      in   1                     APB slave error
// BEHAVIOUR
//  Reset values
//  - All outputs are 0.
//  - State is ST_IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
//  - Reset asserted mid-transfer aborts at once: PSEL/PENABLE drop asynchronously and no req_done is issued.
//  FSM ST_IDLE -> ST_SETUP -> ST_ACCESS -> ST_IDLE
//  - ST_IDLE: if any req_valid, pick the winner by priority order last_grant+1, +2, ... (mod NUM_REQ).
//      - Register its addr/write/wdata into PADDR/PWRITE/PWDATA.
//      - Set req_gnt[w] and last_grant=w; go to ST_SETUP.
//      - No request: stay in ST_IDLE.
//  - ST_SETUP: PSEL=1, PENABLE=0; always go to ST_ACCESS next cycle.
//  - ST_ACCESS: PSEL=1, PENABLE=1.
//      - PREADY=1: req_done[w]=1, rsp_rdata=PRDATA (0 on writes), rsp_err=PSLVERR, all combinational in that cycle; go to ST_IDLE.
//      - PREADY=0: increment wait_cnt.
//      - TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with PREADY=0: req_done[w]=1, rsp_err=1, rsp_rdata=0, timeout_evt=1; go to ST_IDLE.
//  Ownership and exit
//  - req_gnt, PADDR, PWRITE and PWDATA are stable from ST_SETUP until ST_ACCESS exits.
//  - req_gnt clears on the exit edge. PADDR/PWRITE/PWDATA hold their last value in ST_IDLE.
//  Latency and throughput
//  - Minimum latency from req_valid to req_done is 3 cycles (IDLE, SETUP, ACCESS).
//  - Back-to-back transfers always have one ST_IDLE cycle between them, with PSEL=0.
//  Requester protocol
//  - A requester deasserts req_valid, or presents a new request, in the cycle after req_done.
//  - A req_valid drop while granted is ignored; the transfer completes.
//  wait_cnt
//  - Width is $clog2(TIMEOUT+1), minimum 1.
//  - Clears on entry to ST_ACCESS; never wraps.
//  - The counter and watchdog are unused when TIMEOUT=0, and the transfer can wait forever.
//  Fairness
//  - A continuously requesting set is served in strict rotation; no requester waits more than NUM_REQ-1 transfers.
// STRUCTURE
//  - amba_pkg holds: apb_state_t enum {ST_IDLE, ST_SETUP, ST_ACCESS}, and shared HTRANS/HRESP encodings.
//  - Sub-module apb_rr_arbiter (NUM_REQ):
//      - Combinational one-hot pick from req_valid and last_grant.
//      - Owns the last_grant register, updated by an 'accept' strobe.
//  - The top level holds the FSM, the address/data registers and the watchdog.
// TESTING
//  1. Single read: req0 addr=0x40, PRDATA=0xDEADBEEF, PREADY=1 -> PSEL rises in cycle 2, PENABLE in cycle 3; req_done=01, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2. Contention: req0 and req1 held valid for 4 transfers -> grants 0,1,0,1; one PSEL=0 cycle between each.
//  3. Wait states: PREADY low 3 ACCESS cycles on a write of 0x12345678 -> PADDR/PWDATA stable; req_done in ACCESS cycle 4.
//  4. Timeout: TIMEOUT=4, PREADY stuck 0 -> req_done after 4 ACCESS cycles with rsp_err=1, rsp_rdata=0, timeout_evt pulse; next request served normally.
//  5. Slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1 on req_done; last_grant still advances.
//  6. Reset mid-ACCESS: HRESETn low -> PSEL=PENABLE=0 immediately, no req_done; after release, req0 is granted first.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AMBA encodings and the APB master FSM state type.
package amba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // $clog2 clamped to at least one bit so degenerate sizes still give a legal vector.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin one-hot picker. The rotation pointer moves to the winner only
// when the pick is accepted, so an unaccepted pick leaves priority unchanged.
module apb_rr_arbiter
  import amba_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  localparam int IDX_W = width_min1(NUM_REQ);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick_idx;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    int cand;
    cand     = 0;
    gnt_o    = '0;
    any_o    = 1'b0;
    pick_idx = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[IDX_W'(cand)]) begin
        any_o                = 1'b1;
        pick_idx             = IDX_W'(cand);
        gnt_o[IDX_W'(cand)]  = 1'b1;
      end
    end
  end

  assign last_d = (accept_i && any_o) ? pick_idx : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters: round-robin,
// non-preemptive, with PREADY wait states and an optional stall watchdog.
module apb_master_arbiter
  import amba_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          timeout_evt,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR,
  output apb_state_t                    dbg_state
);

  localparam int                WAIT_W    = width_min1(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  apb_state_t              state_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [WAIT_W-1:0]       wait_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic                    arb_any;
  logic                    arb_accept;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;
  logic                    access_ok;
  logic                    wdog_hit;
  logic                    xfer_end;

  assign arb_accept = (state_q == ST_IDLE) && arb_any;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .req_i    (req_valid),
    .accept_i (arb_accept),
    .gnt_o    (arb_gnt),
    .any_o    (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Completion is combinational in the final ACCESS cycle; the watchdog fires
  // on the TIMEOUT-th consecutive stalled ACCESS cycle.
  assign access_ok   = (state_q == ST_ACCESS) && PREADY;
  assign wdog_hit    = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !PREADY && (wait_q == WAIT_LAST);
  assign xfer_end    = access_ok || wdog_hit;
  assign req_done    = {NUM_REQ{xfer_end}} & gnt_q;
  assign rsp_rdata   = (access_ok && !pwrite_q) ? PRDATA : '0;
  assign rsp_err     = access_ok ? PSLVERR : wdog_hit;
  assign timeout_evt = wdog_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q  <= ST_SETUP;
            gnt_q    <= arb_gnt;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            pwrite_q <= sel_write;
            psel_q   <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        ST_ACCESS: begin
          if (xfer_end) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          gnt_q     <= '0;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_gnt   = gnt_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios with literal expectations,
// then randomized requesters/slave checked every cycle against a transfer-level model.
module tb_apb_master_arbiter;
  import amba_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
  localparam int CLK_P   = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #(CLK_P/2) clk = ~clk;

  logic [NUM_REQ-1:0]    req_valid, req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_gnt, req_done;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err, timeout_evt;
  logic                  PSEL, PENABLE, PWRITE;
  logic [AW-1:0]         PADDR;
  logic [DW-1:0]         PWDATA, PRDATA;
  logic                  PREADY, PSLVERR;
  apb_state_t            dbg_state;

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timeout_evt(timeout_evt), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h want=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  // m_phase: 0 = bus free, 1 = address phase, 2 = data phase (m_wait stalls so far)
  int            m_phase, m_owner, m_last, m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_write;

  function automatic int pick_winner();
    for (int k = 1; k <= NUM_REQ; k++)
      if (req_valid[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_owner <= 0; m_last <= NUM_REQ - 1; m_wait <= 0;
      m_addr <= '0; m_wdata <= '0; m_write <= 1'b0;
    end else if (m_phase == 0) begin
      int win;
      win = pick_winner();
      if (win >= 0) begin
        m_phase <= 1; m_owner <= win; m_last <= win;
        m_addr  <= req_addr[win*AW +: AW];
        m_wdata <= req_wdata[win*DW +: DW];
        m_write <= req_write[win];
      end
    end else if (m_phase == 1) begin
      m_phase <= 2; m_wait <= 0;
    end else begin
      if (PREADY || (m_wait == TIMEOUT - 1)) m_phase <= 0;
      else m_wait <= m_wait + 1;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [NUM_REQ-1:0] e_gnt, e_done;
      logic [DW-1:0]      e_rdata;
      logic               e_err, e_tevt;
      apb_state_t         e_state;
      e_gnt   = (m_phase != 0) ? (NUM_REQ'(1) << m_owner) : '0;
      e_done  = '0; e_rdata = '0; e_err = 1'b0; e_tevt = 1'b0;
      e_state = (m_phase == 0) ? ST_IDLE : (m_phase == 1) ? ST_SETUP : ST_ACCESS;
      if (m_phase == 2) begin
        if (PREADY) begin
          e_done  = e_gnt;
          e_rdata = m_write ? '0 : PRDATA;
          e_err   = PSLVERR;
        end else if (m_wait == TIMEOUT - 1) begin
          e_done = e_gnt; e_err = 1'b1; e_tevt = 1'b1;
        end
      end
      chk("psel",    PSEL,        m_phase != 0);
      chk("penable", PENABLE,     m_phase == 2);
      chk("gnt",     req_gnt,     e_gnt);
      chk("paddr",   PADDR,       m_addr);
      chk("pwdata",  PWDATA,      m_wdata);
      chk("pwrite",  PWRITE,      m_write);
      chk("done",    req_done,    e_done);
      chk("rdata",   rsp_rdata,   e_rdata);
      chk("err",     rsp_err,     e_err);
      chk("tevt",    timeout_evt, e_tevt);
      chk("state",   64'(dbg_state), 64'(e_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, output logic [NUM_REQ-1:0] d, output int cyc);
    d = '0; cyc = 0;
    while (d == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      d = req_done;
    end
    chk({name, "_done_seen"}, d != '0, 1'b1);
  endtask

  logic [NUM_REQ-1:0] exp_q[$];
  logic [NUM_REQ-1:0] d, done_s, gnt_s;
  int cyc;

  initial begin
    #(CLK_P * 60000);
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    step();

    // reset state
    chk("rst_psel", PSEL, 0); chk("rst_penable", PENABLE, 0);
    chk("rst_gnt", req_gnt, 0); chk("rst_done", req_done, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_err", rsp_err, 0);
    chk("rst_tevt", timeout_evt, 0); chk("rst_paddr", PADDR, 0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // 1. single read
    set_req(0, 1, 0, 32'h40, '0);
    PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
    @(negedge clk); chk("t1_c1_psel", PSEL, 0);
    @(negedge clk); chk("t1_c2_psel", PSEL, 1); chk("t1_c2_penable", PENABLE, 0);
    chk("t1_c2_paddr", PADDR, 32'h40);
    @(negedge clk); chk("t1_c3_penable", PENABLE, 1); chk("t1_c3_done", req_done, 3'b001);
    chk("t1_c3_rdata", rsp_rdata, 32'hDEADBEEF); chk("t1_c3_err", rsp_err, 0);
    step(); req_valid[0] = 1'b0;
    @(negedge clk); chk("t1_after_psel", PSEL, 0);

    // 2. contention after reset: strict alternation with one idle cycle between
    @(negedge clk); #2; rst_n = 1'b0;
    @(negedge clk); #2; rst_n = 1'b1;
    step();
    set_req(0, 1, 0, 32'h100, '0); set_req(1, 1, 0, 32'h104, '0);
    exp_q = {3'b001, 3'b010, 3'b001, 3'b010};
    for (int k = 0; k < 4; k++) begin
      wait_done("t2", d, cyc);
      chk("t2_gnt", d, exp_q.pop_front());
      chk("t2_latency", cyc, (k == 0) ? 3 : 2);
      step();
      if (k == 3) begin req_valid[0] = 1'b0; req_valid[1] = 1'b0; end
      @(negedge clk); chk("t2_gap_psel", PSEL, 0);
    end
    step();

    // 3. wait states on a write
    set_req(2, 1, 1, 32'h80, 32'h12345678);
    for (int c = 1; c <= 6; c++) begin
      PREADY = (c == 6);
      @(negedge clk);
      if (c >= 2) begin
        chk("t3_paddr", PADDR, 32'h80); chk("t3_pwdata", PWDATA, 32'h12345678);
        chk("t3_pwrite", PWRITE, 1);
      end
      chk("t3_done", req_done, (c == 6) ? 3'b100 : 3'b000);
      if (c == 6) begin chk("t3_err", rsp_err, 0); chk("t3_rdata", rsp_rdata, 0); end
      step();
    end
    req_valid[2] = 1'b0;

    // 4. watchdog abort, then a normal transfer
    set_req(0, 1, 0, 32'hC0, '0);
    PREADY = 1'b0; PRDATA = 32'hAAAA5555;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t4_done", req_done, (c == 6) ? 3'b001 : 3'b000);
      chk("t4_tevt", timeout_evt, c == 6);
      if (c == 6) begin chk("t4_err", rsp_err, 1); chk("t4_rdata", rsp_rdata, 0); end
      step();
    end
    set_req(0, 1, 0, 32'hC4, '0);
    PREADY = 1'b1; PRDATA = 32'h0000600D;
    wait_done("t4b", d, cyc);
    chk("t4b_done", d, 3'b001); chk("t4b_latency", cyc, 3);
    chk("t4b_rdata", rsp_rdata, 32'h600D); chk("t4b_err", rsp_err, 0); chk("t4b_tevt", timeout_evt, 0);
    step();
    req_valid[0] = 1'b0;

    // 5. slave error still advances the rotation
    set_req(1, 1, 1, 32'h10, 32'hCAFE); PSLVERR = 1'b1;
    wait_done("t5", d, cyc);
    chk("t5_done", d, 3'b010); chk("t5_err", rsp_err, 1);
    step();
    PSLVERR = 1'b0;
    set_req(1, 1, 0, 32'h14, '0); set_req(2, 1, 0, 32'h18, '0);
    wait_done("t5b", d, cyc); chk("t5b_winner", d, 3'b100);
    step(); req_valid[2] = 1'b0;
    wait_done("t5c", d, cyc); chk("t5c_winner", d, 3'b010);
    step(); req_valid[1] = 1'b0;

    // 6. asynchronous reset mid-ACCESS
    set_req(1, 1, 0, 32'h20, '0); PREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_in_access", PENABLE, 1);
    #2; rst_n = 1'b0; #1;
    chk("t6_psel", PSEL, 0); chk("t6_penable", PENABLE, 0);
    chk("t6_done", req_done, 0); chk("t6_gnt", req_gnt, 0);
    PREADY = 1'b1;
    set_req(0, 1, 0, 32'h24, '0); set_req(2, 1, 1, 32'h28, 32'h55);
    @(negedge clk); #2; rst_n = 1'b1;
    exp_q = {3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 3; k++) begin
      wait_done("t6r", d, cyc);
      chk("t6r_order", d, exp_q.pop_front());
      step();
      req_valid = req_valid & ~d;
    end

    // 7. randomized requesters and slave
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      done_s = req_done; gnt_s = req_gnt;
      step();
      PREADY  = ($urandom_range(0, 99) < 45);
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done_s[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, $urandom);
          else
            req_valid[i] = 1'b0;
        end else if (gnt_s[i]) begin
          if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, $urandom);
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
